// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution window generator.
package conv_pkg;

  localparam int unsigned DefImgW = 28;
  localparam int unsigned DefImgH = 28;
  localparam int unsigned DefK    = 5;
  localparam int unsigned DefPixW = 8;
  localparam int unsigned WinW    = DefK * DefK * DefPixW;

  typedef logic [DefPixW-1:0] pixel_t;
  typedef logic [WinW-1:0]    window_t;

endpackage

// File: rtl/conv_line_buf.sv
// Single-row delay line: the output is the pixel accepted Depth enables ago.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int unsigned Depth = DefImgW,
  parameter int unsigned Width = DefPixW
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  // Shift one position per enabled cycle.
  always_comb begin
    mem_d = mem_q;
    if (en_i) begin
      mem_d[0] = d_i;
      for (int i = 1; i < Depth; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Contents need no reset: the counters gate every use of stale data.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign q_o = mem_q[Depth-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK window generator over a raster pixel stream (valid positions only).
// Optional build macro CONV_WIN_STRIDE2_EN: emit only windows at even top-left row/col.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = DefImgW,
  parameter int unsigned IMG_H = DefImgH,
  parameter int unsigned K     = DefK,
  parameter int unsigned PIX_W = DefPixW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_pix,
  input  logic                       in_sof,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [K*K*PIX_W-1:0]       win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       win_last
);

  localparam int unsigned RowW    = $clog2(IMG_H);
  localparam int unsigned ColW    = $clog2(IMG_W);
  localparam int unsigned WinBits = K * K * PIX_W;
  localparam int unsigned NumLb   = K - 1;

  logic [RowW-1:0]    pr_q, pr_d, pos_r, tl_r;
  logic [ColW-1:0]    pc_q, pc_d, pos_c, tl_c;
  logic [WinBits-1:0] shift_q, shift_d;
  logic               win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic [WinBits-1:0] win_data_q, win_data_d;
  logic [RowW-1:0]    win_row_q, win_row_d;
  logic [ColW-1:0]    win_col_q, win_col_d;
  logic               accept, take, complete, emit, last_pos;

  logic [PIX_W-1:0] lb_in [NumLb];
  logic [PIX_W-1:0] lb_q  [NumLb];
  logic [PIX_W-1:0] col   [K];

  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;
  assign take     = win_valid_q && win_ready;

  for (genvar i = 0; i < NumLb; i++) begin : g_lb
    conv_line_buf #(
      .Depth(IMG_W),
      .Width(PIX_W)
    ) u_lb (
      .clk_i(clk),
      .en_i (accept),
      .d_i  (lb_in[i]),
      .q_o  (lb_q[i])
    );
  end

  // Chain the line buffers and form the incoming column (bottom row = live pixel).
  always_comb begin
    lb_in[0] = in_pix;
    for (int i = 1; i < NumLb; i++) begin
      lb_in[i] = lb_q[i-1];
    end
    col[K-1] = in_pix;
    for (int i = 0; i < NumLb; i++) begin
      col[K-2-i] = lb_q[i];
    end
  end

  // Position of the accepted pixel and the raster counters that follow it.
  always_comb begin
    pos_r = in_sof ? '0 : pr_q;
    pos_c = in_sof ? '0 : pc_q;
    pr_d  = pr_q;
    pc_d  = pc_q;
    if (accept) begin
      if (pos_c == ColW'(IMG_W - 1)) begin
        pc_d = '0;
        pr_d = (pos_r == RowW'(IMG_H - 1)) ? '0 : pos_r + 1'b1;
      end else begin
        pc_d = pos_c + 1'b1;
        pr_d = pos_r;
      end
    end
  end

  // Window register array shifts left one column per accepted pixel.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          shift_d[PIX_W*(r*K+c) +: PIX_W] = shift_q[PIX_W*(r*K+c+1) +: PIX_W];
        end
        shift_d[PIX_W*(r*K+K-1) +: PIX_W] = col[r];
      end
    end
  end

  // Completion, optional stride filter and last-window detection.
  always_comb begin
    tl_r     = pos_r - RowW'(K - 1);
    tl_c     = pos_c - ColW'(K - 1);
    complete = accept && (pos_r >= RowW'(K - 1)) && (pos_c >= ColW'(K - 1));
`ifdef CONV_WIN_STRIDE2_EN
    emit     = complete && !tl_r[0] && !tl_c[0];
    last_pos = (tl_r == RowW'(IMG_H - K - 1)) && (tl_c == ColW'(IMG_W - K - 1));
`else
    emit     = complete;
    last_pos = (tl_r == RowW'(IMG_H - K)) && (tl_c == ColW'(IMG_W - K));
`endif
  end

  // One-deep output stage: retire on take, load on emit (both in one cycle is fine).
  always_comb begin
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;
    if (take) begin
      win_valid_d = 1'b0;
    end
    if (emit) begin
      win_valid_d = 1'b1;
      win_data_d  = shift_d;
      win_row_d   = tl_r;
      win_col_d   = tl_c;
      win_last_d  = last_pos;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr_q        <= '0;
      pc_q        <= '0;
      shift_q     <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
    end else begin
      pr_q        <= pr_d;
      pc_q        <= pc_d;
      shift_q     <= shift_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen using ramp frames (pixel = raster index mod 256).
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int KK = 5;
  localparam int PW = 8;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int NC   = (W - KK) / S + 1;
  localparam int NR   = (H - KK) / S + 1;
  localparam int NWIN = NC * NR;
  localparam int NPIX = W * H;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  pixel_t         in_pix;
  logic           in_sof;
  logic           win_valid;
  logic           win_ready;
  window_t        win_data;
  logic [4:0]     win_row;
  logic [4:0]     win_col;
  logic           win_last;

  conv_window_gen u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pix   (in_pix),
    .in_sof   (in_sof),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .win_row  (win_row),
    .win_col  (win_col),
    .win_last (win_last)
  );

  always #5 clk = ~clk;

  int      n_chk = 0;
  int      n_bad = 0;
  int      exp_k = 0;
  int      win_cnt = 0;
  int      part_len = -1;
  bit      rand_rdy = 1'b0;
  bit      stalled = 1'b0;
  window_t held;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic window_t exp_win(input int k);
    window_t v;
    int tr, tc;
    tr = (k / NC) * S;
    tc = (k % NC) * S;
    v = '0;
    for (int r = 0; r < KK; r++) begin
      for (int c = 0; c < KK; c++) begin
        v[PW*(r*KK+c) +: PW] = 8'(((tr + r) * W + tc + c) % 256);
      end
    end
    return v;
  endfunction

  // One clock cycle: observe outputs, pick win_ready, drive a pixel, report acceptance.
  task automatic cycle(input bit drive, input int idx, input bit sof, output bit acc);
    window_t ew;
    @(negedge clk);
    if (stalled) begin
      check_eq("stall_valid", win_valid, 1'b1);
      check_eq("stall_data", win_data, held);
    end
    win_ready = rand_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
    in_valid  = drive;
    in_pix    = 8'(idx % 256);
    in_sof    = sof;
    #1;
    check_eq("in_ready", in_ready, !win_valid || win_ready);
    if (win_valid && win_ready) begin
      ew = exp_win(exp_k);
      check_eq("win_row", win_row, (exp_k / NC) * S);
      check_eq("win_col", win_col, (exp_k % NC) * S);
      check_eq("win_last", win_last, exp_k == NWIN - 1);
      check_eq("win_data", win_data, ew);
      if (exp_k == 0) begin
        check_eq("first_e0", win_data[0 +: 8], 8'd0);
        check_eq("first_e4", win_data[32 +: 8], 8'd4);
        check_eq("first_e5", win_data[40 +: 8], 8'd28);
        check_eq("first_e24", win_data[192 +: 8], 8'd116);
      end
      if (exp_k == NWIN - 1) begin
`ifdef CONV_WIN_STRIDE2_EN
        check_eq("last_e0", win_data[0 +: 8], 8'd126);
`else
        check_eq("last_e24", win_data[192 +: 8], 8'd15);
`endif
      end
      win_cnt++;
      exp_k = (exp_k + 1) % NWIN;
      if (exp_k == part_len) begin
        exp_k    = 0;
        part_len = -1;
      end
    end
    stalled = win_valid && !win_ready;
    held    = win_data;
    acc     = drive && in_ready;
  endtask

  task automatic feed(input int n);
    int i = 0;
    int budget = 20 * n;
    bit acc;
    while (i < n && budget > 0) begin
      cycle(1'b1, i, i == 0, acc);
      if (acc) i++;
      budget--;
    end
    check_eq("feed_count", i, n);
  endtask

  task automatic drain();
    int budget = 100;
    bit acc;
    cycle(1'b0, 0, 1'b0, acc);
    while (win_valid && budget > 0) begin
      cycle(1'b0, 0, 1'b0, acc);
      budget--;
    end
    check_eq("drain_idle", win_valid, 1'b0);
  endtask

  task automatic check_reset_state();
    check_eq("rst_win_valid", win_valid, 1'b0);
    check_eq("rst_win_data", win_data, '0);
    check_eq("rst_win_row", win_row, '0);
    check_eq("rst_win_col", win_col, '0);
    check_eq("rst_win_last", win_last, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_sof    = 1'b0;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    // Clean ramp frame, consumer always ready.
    exp_k = 0; win_cnt = 0;
    feed(NPIX);
    drain();
    check_eq("frame1_count", win_cnt, NWIN);

    // Same frame under 30% consumer duty.
    rand_rdy = 1'b1;
    exp_k = 0; win_cnt = 0;
    feed(NPIX);
    drain();
    check_eq("stall_count", win_cnt, NWIN);
    rand_rdy = 1'b0;

    // Two back-to-back frames.
    exp_k = 0; win_cnt = 0;
    feed(NPIX);
    feed(NPIX);
    drain();
    check_eq("b2b_count", win_cnt, 2 * NWIN);

    // Reset after 400 pixels, then a full frame.
    exp_k = 0;
    feed(400);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; win_ready = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    stalled = 1'b0;
    exp_k = 0; win_cnt = 0;
    feed(NPIX);
    drain();
    check_eq("post_rst_count", win_cnt, NWIN);

    // Resync with in_sof after 300 pixels: partial windows, then a clean frame.
`ifdef CONV_WIN_STRIDE2_EN
    part_len = 3 * NC + 8;   // rows 0,2,4 full; row 6 cols 0..14 even
`else
    part_len = 6 * NC + 16;  // rows 0..5 full; row 6 cols 0..15
`endif
    exp_k = 0; win_cnt = 0;
    feed(300);
    feed(NPIX);
    drain();
`ifdef CONV_WIN_STRIDE2_EN
    check_eq("resync_count", win_cnt, 3 * NC + 8 + NWIN);
`else
    check_eq("resync_count", win_cnt, 6 * NC + 16 + NWIN);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
